// File: rtl/burst_line_responder_if.sv
// Cache-side request/line bus plus the word-wide backing-memory bus of burst_line_responder.
// s_error exists only when BURST_RESP_TIMEOUT_EN is defined.
interface burst_line_responder_if #(
   parameter int I_CACHE_LENGTH = 512
);
   logic [31:0]               s_address;
   logic                      s_read;
   logic [4:0]                s_burstcount;
   logic                      s_wait_data;
   logic [I_CACHE_LENGTH-1:0] s_reddata;
   logic [31:0]               mem_address;
   logic                      mem_read;
   logic                      mem_waitrequest;
   logic [31:0]               mem_rdata;
   logic                      mem_rvalid;
`ifdef BURST_RESP_TIMEOUT_EN
   logic                      s_error;
`endif

   // slave: the responder itself; master: cache master plus backing memory
   modport slave (
      input  s_address, s_read, s_burstcount, mem_waitrequest, mem_rdata, mem_rvalid,
      output s_wait_data, s_reddata, mem_address, mem_read
`ifdef BURST_RESP_TIMEOUT_EN
      , output s_error
`endif
   );

   modport master (
      output s_address, s_read, s_burstcount, mem_waitrequest, mem_rdata, mem_rvalid,
      input  s_wait_data, s_reddata, mem_address, mem_read
`ifdef BURST_RESP_TIMEOUT_EN
      , input s_error
`endif
   );
endinterface

// File: rtl/burst_line_responder.sv
// Fetches one cache line as N word reads (issue and return may overlap) and assembles it.
// BURST_RESP_TIMEOUT_EN adds s_error and a 255-cycle no-return watchdog.
module burst_line_responder #(
   parameter int I_BURST        = 16,
   parameter int I_CACHE_LENGTH = I_BURST*32
) (
   input  logic                 clk,
   input  logic                 resetn,
   burst_line_responder_if.slave bus
);
   localparam int         KW   = $clog2(I_BURST);
   localparam logic [4:0] BMAX = 5'(I_BURST);

   typedef enum logic {IDLE, FETCH} state_t;

   typedef struct packed {
      logic [31:0] base;
      logic [4:0]  n;
   } burst_t;

   state_t                    state, state_nx;
   burst_t                    cur;
   logic [4:0]                issue_cnt, ret_cnt;
   logic [I_BURST-1:0][31:0]  line;
   logic [4:0]                req_n;
   logic                      accept, issue_fire, ret_fire, last_ret, timeout;
   logic                      wait_o, read_o;
   logic [31:0]               addr_o;

   assign req_n      = (bus.s_burstcount == 5'd0 || bus.s_burstcount > BMAX) ? BMAX : bus.s_burstcount;
   assign accept     = (state == IDLE) && bus.s_read;
   assign issue_fire = read_o && !bus.mem_waitrequest;
   // returns outside a burst (idle, or after a reset abandoned one) are dropped
   assign ret_fire   = (state == FETCH) && bus.mem_rvalid;
   assign last_ret   = ret_fire && (ret_cnt == cur.n - 5'd1);

`ifdef BURST_RESP_TIMEOUT_EN
   logic [7:0] idle_cnt;
   logic       err_q;

   assign timeout     = (state == FETCH) && (idle_cnt == 8'hFF);
   assign bus.s_error = err_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         idle_cnt <= '0;
         err_q    <= 1'b0;
      end else if (accept) begin
         idle_cnt <= '0;
         err_q    <= 1'b0;
      end else if (state == FETCH) begin
         if (bus.mem_rvalid)          idle_cnt <= '0;
         else if (idle_cnt != 8'hFF)  idle_cnt <= idle_cnt + 8'd1;
         if (timeout)                 err_q <= 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.s_read) state_nx = FETCH;
         FETCH:   if (last_ret || timeout) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      wait_o = 1'b0;
      read_o = 1'b0;
      addr_o = '0;
      if (state == FETCH) begin
         wait_o = 1'b1;
         read_o = (issue_cnt < cur.n);
         if (read_o) addr_o = cur.base + {25'd0, issue_cnt, 2'b00};
      end
   end

   assign bus.s_wait_data = wait_o;
   assign bus.mem_read    = read_o;
   assign bus.mem_address = addr_o;
   assign bus.s_reddata   = I_CACHE_LENGTH'(line);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cur       <= '0;
         issue_cnt <= '0;
         ret_cnt   <= '0;
         line      <= '0;
      end else if (accept) begin
         cur.base  <= {bus.s_address[31:6], 6'd0};
         cur.n     <= req_n;
         issue_cnt <= '0;
         ret_cnt   <= '0;
         line      <= '0;
      end else if (state == FETCH) begin
         if (issue_fire) issue_cnt <= issue_cnt + 5'd1;
         if (ret_fire) begin
            line[ret_cnt[KW-1:0]] <= bus.mem_rdata;
            ret_cnt               <= ret_cnt + 5'd1;
         end
      end
   end
endmodule

// File: doc/burst_line_responder.md
BURST_LINE_RESPONDER -- requirements
Module: burst_line_responder

Interface
REQ-001 SHALL have parameter: I_BURST, 16, maximum words per burst (one cache line).
REQ-002 SHALL have parameter: I_CACHE_LENGTH, I_BURST*32, line width in bits.
REQ-003 SHALL have port: clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port: resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: s_address  input  32  line request address from the cache master.
REQ-006 SHALL have port: s_read  input  1  read request, sampled when idle.
REQ-007 SHALL have port: s_burstcount  input  5  words requested.
REQ-008 SHALL have port: s_wait_data  output  1  high while a burst is in progress.
REQ-009 SHALL have port: s_reddata  output  I_CACHE_LENGTH  assembled line.
REQ-010 SHALL have port: mem_address  output  32  word byte-address to backing memory.
REQ-011 SHALL have port: mem_read  output  1  word read request.
REQ-012 SHALL have port: mem_waitrequest  input  1  memory stalls current request.
REQ-013 SHALL have port: mem_rdata  input  32  returned word.
REQ-014 SHALL have port: mem_rvalid  input  1  mem_rdata valid, in-order returns.

Function
REQ-015 SHALL implement FSM states IDLE and FETCH.
REQ-016 SHALL, in IDLE with s_read=1 at a clock edge, latch base={s_address[31:6],6'd0} and word count N, enter FETCH, and drive s_wait_data=1 from the next cycle.
REQ-017 SHALL set N=s_burstcount for 1..16; values 0 or >16 SHALL be treated as 16.
REQ-018 SHALL ignore s_read while in FETCH; base, N and s_reddata SHALL not change.
REQ-019 SHALL, in FETCH, drive mem_read=1 with mem_address=base+4*i while issue count i<N; i SHALL advance only on cycles with mem_read=1 and mem_waitrequest=0.
REQ-020 SHALL, on each mem_rvalid in FETCH, write mem_rdata to s_reddata bits [32k+31:32k], k = return count, and then increment k.
REQ-021 SHALL, on the edge capturing return N-1, clear s_wait_data and return to IDLE; s_reddata SHALL be complete in the first cycle s_wait_data=0.
REQ-022 SHALL, on accepting a new request, clear s_reddata to zero; words k>=N SHALL remain zero.
REQ-023 SHALL hold s_reddata stable in IDLE until the next accepted request.
REQ-024 SHALL ignore mem_rvalid in IDLE and any mem_rvalid beyond N in FETCH.
REQ-025 SHALL support issue and return in the same cycle; minimum latency from s_read edge to s_wait_data=0 SHALL be N+1 cycles with zero-wait memory returning one cycle after issue.

Reset
REQ-026 SHALL, while resetn=0, force state=IDLE, s_wait_data=0, s_reddata=0, mem_read=0, mem_address=0, and all counters to 0, independent of clk.
REQ-027 SHALL, on reset during FETCH, abandon the burst; late mem_rvalid after reset SHALL be ignored per REQ-024.

Configuration
REQ-028 SHALL provide macro BURST_RESP_TIMEOUT_EN.
REQ-029 SHALL, with BURST_RESP_TIMEOUT_EN defined, add output s_error (1 bit, reset 0) and an 8-bit idle counter cleared on entering FETCH and on each mem_rvalid, incremented otherwise in FETCH.
REQ-030 SHALL, with the macro defined and the counter reaching 255, end the burst: deassert mem_read, clear s_wait_data, return to IDLE with remaining words zero, and set s_error=1 until the next accepted request.
REQ-031 SHALL, without the macro, have no s_error port and wait indefinitely for returns.

Verification
REQ-032 SHALL test: s_address=0x0000_1234, s_burstcount=16, zero-wait memory returning word=address -> mem_address 0x1200..0x123C, s_wait_data low after 17 cycles, s_reddata[31:0]=0x1200 and [511:480]=0x123C.
REQ-033 SHALL test: s_burstcount=4 -> exactly 4 mem_read issues, s_reddata[511:128]=0.
REQ-034 SHALL test: mem_waitrequest=1 for 3 cycles on word 5 -> mem_address held at base+0x14 during the stall, line still correct, latency +3.
REQ-035 SHALL test: s_read pulsed again mid-FETCH with 0x8000_0000 -> ignored, line from the original base returned.
REQ-036 SHALL test: resetn low after 7 returns -> s_wait_data=0, s_reddata=0 immediately; the next request completes correctly.
REQ-037 SHALL test (macro defined): memory stops after 10 returns -> s_wait_data=0 and s_error=1 after 255 idle cycles, words 10..15 zero.
